// File: rtl/wbm_pkg.sv
// wbm_pkg: shared definitions for the single-transaction Wishbone initiator.
//   - Default bus geometry (word-address width, data width).
//   - Default timeout exponent, used when WBM_TIMEOUT_EN is defined.
//   - Controller state encoding, which is also exported on the debug port.
package wbm_pkg;

  localparam int unsigned WBM_AW         = 30;
  localparam int unsigned WBM_DW         = 32;
  localparam int unsigned WBM_TIMEOUT_LG = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,  // waiting for a command; command port open
    ST_REQ  = 2'b01,  // cyc=1, stb=1, waiting for the slave to drop stall
    ST_WAIT = 2'b10   // request accepted, waiting for ack/err
  } wbm_state_e;

endpackage

// File: rtl/wbm_watchdog.sv
// wbm_watchdog: bus-cycle timeout counter.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_clear        : zero the counter (asserted on the cycle before cyc rises)
//   i_enable       : count this cycle (cyc is high)
//   o_expired      : counter at all-ones while enabled -> abort the cycle
// Only instantiated when WBM_TIMEOUT_EN is defined.
module wbm_watchdog #(
  parameter int unsigned CNT_W = 10
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The counter reads 0 on the first cyc cycle, so all-ones is reached on
  // the (2**CNT_W)th cycle of the bus cycle; cyc drops one cycle later.
  assign o_expired = i_enable && (cnt_q == {CNT_W{1'b1}});

endmodule

// File: rtl/wbm_single.sv
// wbm_single: Wishbone B4 pipelined initiator, one read/write per command.
//
// Command side (valid/ready contract):
//   A command is taken on any cycle where i_cmd_stb=1 and o_cmd_busy=0.
//   i_cmd_stb while o_cmd_busy=1 is ignored; there is no back-pressure
//   other than busy. Each accepted command yields exactly one o_rsp_stb
//   pulse (unless i_reset intervenes); o_rsp_err is only ever high together
//   with o_rsp_stb. o_rsp_data updates only on a read ack without err.
//
// Ports:
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_cmd_stb/we/addr/data/sel     command request
//   o_cmd_busy                     transaction outstanding
//   o_rsp_stb/err/data             completion pulse, error flag, read data
//   o_wb_cyc/stb/we/addr/data/sel  Wishbone master outputs
//   i_wb_stall/ack/err/data        Wishbone slave responses
//   o_dbg_state                    controller state (debug)
//
// Build option: define WBM_TIMEOUT_EN to abort bus cycles that see no
// ack/err within 2**TIMEOUT_LG cycles (reported as an error response).
module wbm_single
  import wbm_pkg::*;
#(
  parameter int unsigned AW         = WBM_AW,
  parameter int unsigned DW         = WBM_DW,
  parameter int unsigned TIMEOUT_LG = WBM_TIMEOUT_LG
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_cmd_stb,
  input  logic            i_cmd_we,
  input  logic [AW-1:0]   i_cmd_addr,
  input  logic [DW-1:0]   i_cmd_data,
  input  logic [DW/8-1:0] i_cmd_sel,
  output logic            o_cmd_busy,
  output logic            o_rsp_stb,
  output logic            o_rsp_err,
  output logic [DW-1:0]   o_rsp_data,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack,
  input  logic            i_wb_err,
  input  logic [DW-1:0]   i_wb_data,
  output wbm_state_e      o_dbg_state
);

  // Elaboration-time parameter sanity checks.
  if ((DW % 8) != 0) begin : g_dw_check
    $error("wbm_single: DW must be a multiple of 8");
  end
  if (TIMEOUT_LG == 0) begin : g_lg_check
    $error("wbm_single: TIMEOUT_LG must be at least 1");
  end

  wbm_state_e      state_q, state_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic [DW/8-1:0] sel_q, sel_d;
  logic            rsp_stb_q, rsp_stb_d;
  logic            rsp_err_q, rsp_err_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;

  logic cyc;
  logic cmd_take;
  logic expired;
  logic bus_done;

  // cyc/stb are pure decodes of the registered state, so they are glitch
  // free and change exactly one cycle after the decision that moves state.
  assign cyc      = (state_q != ST_IDLE);
  assign cmd_take = (state_q == ST_IDLE) && i_cmd_stb;

`ifdef WBM_TIMEOUT_EN
  wbm_watchdog #(
    .CNT_W (TIMEOUT_LG)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (cmd_take),
    .i_enable  (cyc),
    .o_expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  // ack/err are honoured in REQ as well as WAIT, even while stalled, so a
  // misbehaving slave cannot wedge the master.
  assign bus_done = cyc && (i_wb_ack || i_wb_err || expired);

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    data_d     = data_q;
    sel_d      = sel_q;
    rsp_stb_d  = 1'b0;
    rsp_err_d  = 1'b0;
    rsp_data_d = rsp_data_q;

    case (state_q)
      ST_IDLE: begin
        if (i_cmd_stb) begin
          we_d    = i_cmd_we;
          addr_d  = i_cmd_addr;
          data_d  = i_cmd_data;
          sel_d   = i_cmd_sel;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!bus_done && !i_wb_stall) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        state_d = ST_WAIT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (bus_done) begin
      state_d   = ST_IDLE;
      rsp_stb_d = 1'b1;
      // err beats ack; a timeout only counts when no ack arrived with it.
      rsp_err_d = i_wb_err || (expired && !i_wb_ack);
      if (i_wb_ack && !i_wb_err && !we_q) begin
        rsp_data_d = i_wb_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      sel_q      <= '0;
      rsp_stb_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      sel_q      <= sel_d;
      rsp_stb_q  <= rsp_stb_d;
      rsp_err_q  <= rsp_err_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign o_cmd_busy  = cyc;
  assign o_rsp_stb   = rsp_stb_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_wb_cyc    = cyc;
  assign o_wb_stb    = (state_q == ST_REQ);
  assign o_wb_we     = we_q;
  assign o_wb_addr   = addr_q;
  assign o_wb_data   = data_q;
  assign o_wb_sel    = sel_q;
  assign o_dbg_state = state_q;

endmodule
